debouncer_bank: RTL and testbench

DEBOUNCER_BANK -- requirements
Module: debouncer_bank

---
 rtl/debounce_pkg.sv | 21 ++
 rtl/debounce_ch.sv | 73 +++++++
 rtl/debouncer_bank.sv | 51 +++++
 tb/tb_debouncer_bank.sv | 144 ++++++++++++++
 4 files changed

// File: rtl/debounce_pkg.sv
// Shared constants and helpers for the button debouncer bank.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package debounce_pkg;

  localparam int DEB_PRESS_CNT_DFLT   = 4095;
  localparam int DEB_RELEASE_CNT_DFLT = 4095;

  // Counter width able to hold max(press,release)-1; never narrower than 1 bit.
  function automatic int deb_cnt_width(input int press_cnt, input int release_cnt);
    int m;
    int w;
    m = (press_cnt > release_cnt) ? press_cnt : release_cnt;
    w = 1;
    while ((1 << w) < m) begin
      w = w + 1;
    end
    return w;
  endfunction

endpackage

// File: rtl/debounce_ch.sv
// One debounce channel: 2-flop synchronizer, qualification counter, level and edge pulses.
// Latency: level follows a clean edge THRESH ticks after the synchronized value differs (2+THRESH clk edges incl. the sampling edge).
// Backpressure: none; tick_en only gates counter progress, pulses never wait.
module debounce_ch
  import debounce_pkg::*;
#(
  parameter int PRESS_CNT   = DEB_PRESS_CNT_DFLT,
  parameter int RELEASE_CNT = DEB_RELEASE_CNT_DFLT,
  parameter int CW          = deb_cnt_width(PRESS_CNT, RELEASE_CNT)
) (
  input  logic clk,
  input  logic rst_n,
  input  logic tick_en,
  input  logic btn,
  output logic level,
  output logic rise,
  output logic fall,
  output logic chg_nxt
);

  localparam logic [CW-1:0] PRESS_M1   = CW'(PRESS_CNT - 1);
  localparam logic [CW-1:0] RELEASE_M1 = CW'(RELEASE_CNT - 1);

  logic          meta;
  logic          sync;
  logic [CW-1:0] cnt;
  logic [CW-1:0] thresh_m1;
  logic          differ;

  // Threshold depends on the direction of the pending change.
  always_comb begin
    thresh_m1 = level ? RELEASE_M1 : PRESS_M1;
    differ    = tick_en && (sync != level);
    chg_nxt   = differ && (cnt >= thresh_m1);
  end

  // Two-stage synchronizer for the asynchronous button input.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta <= 1'b0;
      sync <= 1'b0;
    end else begin
      meta <= btn;
      sync <= meta;
    end
  end

  // Count consecutive disagreeing ticks; any agreeing tick discards progress.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt   <= '0;
      level <= 1'b0;
      rise  <= 1'b0;
      fall  <= 1'b0;
    end else begin
      rise <= 1'b0;
      fall <= 1'b0;
      if (tick_en) begin
        if (!differ) begin
          cnt <= '0;
        end else if (!chg_nxt) begin
          cnt <= cnt + 1'b1;
        end else begin
          cnt   <= '0;
          level <= ~level;
          rise  <= ~level;
          fall  <= level;
        end
      end
    end
  end

endmodule

// File: rtl/debouncer_bank.sv
// Bank of NUM_CH independent button debouncers with a combined change strobe.
// Latency: per channel 2+THRESH clk edges from sampling edge to level/pulse; any_change aligned with pulses.
// Backpressure: none; tick_en gates sampling progress for every channel alike.
module debouncer_bank
  import debounce_pkg::*;
#(
  parameter int NUM_CH      = 4,
  parameter int PRESS_CNT   = DEB_PRESS_CNT_DFLT,
  parameter int RELEASE_CNT = DEB_RELEASE_CNT_DFLT
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              tick_en,
  input  logic [NUM_CH-1:0] btn,
  output logic [NUM_CH-1:0] level,
  output logic [NUM_CH-1:0] rise,
  output logic [NUM_CH-1:0] fall,
  output logic              any_change
);

  localparam int CW = deb_cnt_width(PRESS_CNT, RELEASE_CNT);

  logic [NUM_CH-1:0] chg_nxt;

  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    debounce_ch #(
      .PRESS_CNT  (PRESS_CNT),
      .RELEASE_CNT(RELEASE_CNT),
      .CW         (CW)
    ) u_ch (
      .clk    (clk),
      .rst_n  (rst_n),
      .tick_en(tick_en),
      .btn    (btn[g]),
      .level  (level[g]),
      .rise   (rise[g]),
      .fall   (fall[g]),
      .chg_nxt(chg_nxt[g])
    );
  end

  // Register the OR of next-cycle pulses so any_change lines up with rise/fall.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      any_change <= 1'b0;
    end else begin
      any_change <= |chg_nxt;
    end
  end

endmodule

// File: tb/tb_debouncer_bank.sv
module tb_debouncer_bank;

  logic       clk;
  logic       rst_n;
  logic       tick_en;
  logic [3:0] btn;
  logic [3:0] level;
  logic [3:0] rise;
  logic [3:0] fall;
  logic       any_change;

  int n_pass  = 0;
  int n_total = 0;

  typedef struct {
    logic [3:0] btn;
    logic       tick;
    logic [3:0] lvl;
    logic [3:0] rise;
    logic [3:0] fall;
    logic       any;
  } vec_t;

  vec_t tbl[$];

  debouncer_bank #(
    .NUM_CH     (4),
    .PRESS_CNT  (4),
    .RELEASE_CNT(8)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .tick_en   (tick_en),
    .btn       (btn),
    .level     (level),
    .rise      (rise),
    .fall      (fall),
    .any_change(any_change)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [12:0] act, input logic [12:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got lvl/rise/fall/any=%h/%h/%h/%b required %h/%h/%h/%b",
                  name, act[12:9], act[8:5], act[4:1], act[0],
                  exp[12:9], exp[8:5], exp[4:1], exp[0]);
  endtask

  // Drive inputs on the falling edge, then check the state after the next rising edge.
  task automatic step(input logic [3:0] b, input logic t, input logic [3:0] el,
                      input logic [3:0] er, input logic [3:0] ef, input logic ea,
                      input string name);
    @(negedge clk);
    btn     = b;
    tick_en = t;
    @(posedge clk);
    #1;
    check(name, {level, rise, fall, any_change}, {el, er, ef, ea});
  endtask

  task automatic add(input logic [3:0] b, input logic t, input logic [3:0] el,
                     input logic [3:0] er, input logic [3:0] ef, input logic ea);
    vec_t v;
    v.btn = b; v.tick = t; v.lvl = el; v.rise = er; v.fall = ef; v.any = ea;
    tbl.push_back(v);
  endtask

  initial begin
    // Row k of each sequence is the k-th rising edge after the inputs change;
    // edge 1 samples the new value, so press lands on edge 6, release on edge 10.
    for (int k = 1; k <= 5; k++) add(4'b0001, 1'b1, 4'b0000, 4'b0000, 4'b0000, 1'b0);
    add(4'b0001, 1'b1, 4'b0001, 4'b0001, 4'b0000, 1'b1);
    for (int k = 1; k <= 3; k++) add(4'b0001, 1'b1, 4'b0001, 4'b0000, 4'b0000, 1'b0);
    for (int k = 1; k <= 9; k++) add(4'b0000, 1'b1, 4'b0001, 4'b0000, 4'b0000, 1'b0);
    add(4'b0000, 1'b1, 4'b0000, 4'b0000, 4'b0001, 1'b1);
    add(4'b0000, 1'b1, 4'b0000, 4'b0000, 4'b0000, 1'b0);

    rst_n   = 1'b0;
    tick_en = 1'b1;
    btn     = 4'b0000;
    #1;
    check("reset state", {level, rise, fall, any_change}, 13'd0);
    #1;
    rst_n = 1'b1;

    // Press and release of channel 0 with a long hold.
    for (int i = 0; i < tbl.size(); i++)
      step(tbl[i].btn, tbl[i].tick, tbl[i].lvl, tbl[i].rise, tbl[i].fall, tbl[i].any,
           $sformatf("ch0 press/release row %0d", i + 1));

    // Channel 1 bounces high for 3 edges at a time: never qualifies.
    for (int r = 0; r < 5; r++) begin
      for (int k = 0; k < 3; k++) step(4'b0010, 1'b1, 4'b0000, 4'b0000, 4'b0000, 1'b0, $sformatf("ch1 bounce hi r%0d", r));
      for (int k = 0; k < 3; k++) step(4'b0000, 1'b1, 4'b0000, 4'b0000, 4'b0000, 1'b0, $sformatf("ch1 bounce lo r%0d", r));
    end

    // Channel 2: reach level 1, then a 7-edge low glitch, then a real release.
    for (int k = 1; k <= 5; k++) step(4'b0100, 1'b1, 4'b0000, 4'b0000, 4'b0000, 1'b0, $sformatf("ch2 press e%0d", k));
    step(4'b0100, 1'b1, 4'b0100, 4'b0100, 4'b0000, 1'b1, "ch2 press e6");
    step(4'b0100, 1'b1, 4'b0100, 4'b0000, 4'b0000, 1'b0, "ch2 press e7");
    for (int k = 1; k <= 7; k++) step(4'b0000, 1'b1, 4'b0100, 4'b0000, 4'b0000, 1'b0, $sformatf("ch2 glitch lo e%0d", k));
    for (int k = 1; k <= 4; k++) step(4'b0100, 1'b1, 4'b0100, 4'b0000, 4'b0000, 1'b0, $sformatf("ch2 glitch hi e%0d", k));
    for (int k = 1; k <= 9; k++) step(4'b0000, 1'b1, 4'b0100, 4'b0000, 4'b0000, 1'b0, $sformatf("ch2 release e%0d", k));
    step(4'b0000, 1'b1, 4'b0000, 4'b0000, 4'b0100, 1'b1, "ch2 release e10");
    step(4'b0000, 1'b1, 4'b0000, 4'b0000, 4'b0000, 1'b0, "ch2 release e11");

    // Channel 3 with a tick every 4th edge: ticks at edges 4,8,12,16 -> rise on edge 16.
    for (int k = 1; k <= 15; k++)
      step(4'b1000, (k % 4) == 0, 4'b0000, 4'b0000, 4'b0000, 1'b0, $sformatf("ch3 slow tick e%0d", k));
    step(4'b1000, 1'b1, 4'b1000, 4'b1000, 4'b0000, 1'b1, "ch3 slow tick e16");
    step(4'b1000, 1'b0, 4'b1000, 4'b0000, 4'b0000, 1'b0, "ch3 slow tick e17");

    // Channel 0 part-way through qualification (cnt=2 after edge 4), then reset.
    for (int k = 1; k <= 4; k++) step(4'b1001, 1'b1, 4'b1000, 4'b0000, 4'b0000, 1'b0, $sformatf("pre-reset e%0d", k));
    #2;
    rst_n = 1'b0;
    #1;
    check("async reset clears", {level, rise, fall, any_change}, 13'd0);
    @(posedge clk);
    #1;
    check("reset held over edge", {level, rise, fall, any_change}, 13'd0);
    #1;
    rst_n = 1'b1;
    for (int k = 1; k <= 5; k++) step(4'b1001, 1'b1, 4'b0000, 4'b0000, 4'b0000, 1'b0, $sformatf("post-reset e%0d", k));
    step(4'b1001, 1'b1, 4'b1001, 4'b1001, 4'b0000, 1'b1, "post-reset e6");
    step(4'b1001, 1'b1, 4'b1001, 4'b0000, 4'b0000, 1'b0, "post-reset e7");

    // Release both, then press channels 0 and 3 on the same edge.
    for (int k = 1; k <= 9; k++) step(4'b0000, 1'b1, 4'b1001, 4'b0000, 4'b0000, 1'b0, $sformatf("dual release e%0d", k));
    step(4'b0000, 1'b1, 4'b0000, 4'b0000, 4'b1001, 1'b1, "dual release e10");
    step(4'b0000, 1'b1, 4'b0000, 4'b0000, 4'b0000, 1'b0, "dual release e11");
    for (int k = 1; k <= 5; k++) step(4'b1001, 1'b1, 4'b0000, 4'b0000, 4'b0000, 1'b0, $sformatf("dual press e%0d", k));
    step(4'b1001, 1'b1, 4'b1001, 4'b1001, 4'b0000, 1'b1, "dual press e6");
    step(4'b1001, 1'b1, 4'b1001, 4'b0000, 4'b0000, 1'b0, "dual press e7");
    step(4'b1001, 1'b1, 4'b1001, 4'b0000, 4'b0000, 1'b0, "dual press e8");

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
